// File: rtl/dma_csr_pkg.sv
// Shared definitions for the DMA CSR block: register map, bit positions and
// the status-update FSM state encoding.
package dma_csr_pkg;

  localparam int STATUS_ADDR    = 0;
  localparam int CONTROL_ADDR   = 1;
  localparam int IRQ_COUNT_ADDR = 2;

  localparam int IRQ_PENDING_BIT = 31;
  localparam int IE_BIT          = 0;

  localparam int IRQ_COUNT_W = 16;

  typedef logic [1:0] upd_state_t;

  localparam upd_state_t IDLE    = 2'd0;
  localparam upd_state_t UPDATE  = 2'd1;
  localparam upd_state_t ACK     = 2'd2;
  localparam upd_state_t RELEASE = 2'd3;

endpackage

// File: rtl/dma_csr_update_fsm.sv
// Handshake FSM for status-update requests: accepts a held request, pulses a
// one-cycle load into STATUS, acks, then waits for the request to drop.
module dma_csr_update_fsm
  import dma_csr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rq_i,
  input  logic host_status_wr_i,
  output logic load_o,
  output logic ack_o
);

  upd_state_t state_q, state_d;
  logic       ack_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      // A host write to STATUS in the same cycle defers acceptance by one cycle.
      IDLE:    if (rq_i && !host_status_wr_i) state_d = UPDATE;
      UPDATE:  state_d = ACK;
      ACK:     state_d = rq_i ? RELEASE : IDLE;
      RELEASE: if (!rq_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
    end
  end

  assign load_o = (state_q == UPDATE);
  assign ack_o  = ack_q;

endmodule

// File: rtl/dma_csr.sv
// DMA control/status register block with status-update handshake and level IRQ.
// Optional IRQ_COUNT register at address 2 is enabled by DMA_CSR_IRQ_COUNT_EN.
module dma_csr
  import dma_csr_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic [3:0]        csr_byteenable,
  output logic [31:0]       csr_readdata,
  output logic              csr_readdatavalid,
  input  logic [31:0]       csr_status_update_i,
  input  logic [3:0]        csr_status_update_be_i,
  input  logic              csr_status_update_rq_i,
  output logic              csr_status_update_ack_o,
  input  logic              dma_interrupt_rq_i,
  output logic [31:0]       csr_control_o,
  output logic              irq_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] control_q, control_d;
  logic [31:0] readdata_q, readdata_d;
  logic        readdatavalid_q;
  logic [31:0] irq_count_rd;
  logic        status_wr, control_wr, pending_clr, status_load;
  logic        unused_update_msb;

  assign status_wr   = csr_write && (csr_address == ADDR_W'(STATUS_ADDR));
  assign control_wr  = csr_write && (csr_address == ADDR_W'(CONTROL_ADDR));
  assign pending_clr = status_wr && csr_byteenable[3] && csr_writedata[IRQ_PENDING_BIT];

  // Bit 31 of the update word has no destination: IRQ_PENDING is host/event owned.
  assign unused_update_msb = csr_status_update_i[31];

  dma_csr_update_fsm u_update_fsm (
    .clk              (clk),
    .reset            (reset),
    .rq_i             (csr_status_update_rq_i),
    .host_status_wr_i (status_wr),
    .load_o           (status_load),
    .ack_o            (csr_status_update_ack_o)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign control_d[8*gi +: 8] = (control_wr && csr_byteenable[gi]) ?
                                    csr_writedata[8*gi +: 8] : control_q[8*gi +: 8];
      if (gi < 3) begin : g_full
        assign status_d[8*gi +: 8] = (status_load && csr_status_update_be_i[gi]) ?
                                     csr_status_update_i[8*gi +: 8] : status_q[8*gi +: 8];
      end else begin : g_top
        assign status_d[30:24] = (status_load && csr_status_update_be_i[3]) ?
                                 csr_status_update_i[30:24] : status_q[30:24];
      end
    end
  endgenerate

  // A new interrupt event beats a simultaneous host clear.
  assign status_d[IRQ_PENDING_BIT] = dma_interrupt_rq_i |
                                     (status_q[IRQ_PENDING_BIT] & ~pending_clr);

`ifdef DMA_CSR_IRQ_COUNT_EN
  logic [IRQ_COUNT_W-1:0] irq_count_q, irq_count_d;
  logic                   irq_count_wr;

  assign irq_count_wr = csr_write && (csr_address == ADDR_W'(IRQ_COUNT_ADDR));

  always_comb begin
    irq_count_d = irq_count_q;
    if (irq_count_wr)
      irq_count_d = '0;
    else if (dma_interrupt_rq_i && (irq_count_q != {IRQ_COUNT_W{1'b1}}))
      irq_count_d = irq_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) irq_count_q <= '0;
    else       irq_count_q <= irq_count_d;
  end

  assign irq_count_rd = {{(32-IRQ_COUNT_W){1'b0}}, irq_count_q};
`else
  assign irq_count_rd = 32'h0;
`endif

  always_comb begin
    readdata_d = 32'h0;
    if (csr_address == ADDR_W'(STATUS_ADDR))
      readdata_d = status_q;
    else if (csr_address == ADDR_W'(CONTROL_ADDR))
      readdata_d = control_q;
    else if (csr_address == ADDR_W'(IRQ_COUNT_ADDR))
      readdata_d = irq_count_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q        <= 32'h0;
      control_q       <= 32'h0;
      readdata_q      <= 32'h0;
      readdatavalid_q <= 1'b0;
    end else begin
      status_q        <= status_d;
      control_q       <= control_d;
      readdatavalid_q <= csr_read;
      if (csr_read) readdata_q <= readdata_d;
    end
  end

  assign csr_readdata      = readdata_q;
  assign csr_readdatavalid = readdatavalid_q;
  assign csr_control_o     = control_q;
  assign irq_o             = status_q[IRQ_PENDING_BIT] & control_q[IE_BIT];

endmodule

// File: tb/tb_dma_csr.sv
// Randomized bench for dma_csr with a cycle-indexed reference model; honours
// DMA_CSR_IRQ_COUNT_EN when the design is built with it.
module tb_dma_csr;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] csr_address;
  logic              csr_read, csr_write;
  logic [31:0]       csr_writedata;
  logic [3:0]        csr_byteenable;
  logic [31:0]       csr_readdata;
  logic              csr_readdatavalid;
  logic [31:0]       csr_status_update_i;
  logic [3:0]        csr_status_update_be_i;
  logic              csr_status_update_rq_i;
  logic              csr_status_update_ack_o;
  logic              dma_interrupt_rq_i;
  logic [31:0]       csr_control_o;
  logic              irq_o;

  always #5 clk = ~clk;

  dma_csr #(.ADDR_W(ADDR_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .csr_address            (csr_address),
    .csr_read               (csr_read),
    .csr_write              (csr_write),
    .csr_writedata          (csr_writedata),
    .csr_byteenable         (csr_byteenable),
    .csr_readdata           (csr_readdata),
    .csr_readdatavalid      (csr_readdatavalid),
    .csr_status_update_i    (csr_status_update_i),
    .csr_status_update_be_i (csr_status_update_be_i),
    .csr_status_update_rq_i (csr_status_update_rq_i),
    .csr_status_update_ack_o(csr_status_update_ack_o),
    .dma_interrupt_rq_i     (dma_interrupt_rq_i),
    .csr_control_o          (csr_control_o),
    .irq_o                  (irq_o)
  );

  // Staged host-side stimulus, applied inside tick just after the falling edge.
  logic              h_reset, h_read, h_write, h_irq;
  logic [ADDR_W-1:0] h_addr;
  logic [31:0]       h_wd;
  logic [3:0]        h_be;

  // Update initiator: raises a request, holds it until ack, then maybe lingers.
  bit          ini_go, ini_active, ini_acked;
  int          ini_hold;
  logic [31:0] ini_data;
  logic [3:0]  ini_be;
  int          start_cyc, last_ack_cyc;

  // Reference model: register contents plus the cycle a request was accepted.
  logic [31:0] m_status, m_control, m_rdata;
  logic        m_rvalid;
`ifdef DMA_CSR_IRQ_COUNT_EN
  int          m_cnt;
`endif
  int          cyc, acc;
  bit          acc_valid, busy;

  int vectors, miscompares;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return m_status;
      1: return m_control;
`ifdef DMA_CSR_IRQ_COUNT_EN
      2: return 32'(m_cnt);
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle_host();
    h_reset = 1'b0; h_read = 1'b0; h_write = 1'b0; h_irq = 1'b0;
    h_addr = '0; h_wd = 32'h0; h_be = 4'h0;
  endtask

  task automatic tick(input bit rand_host, input bit auto_req);
    bit          ackn, st_wr;
    logic [31:0] merged;
    @(negedge clk);
    check_eq("irq", {31'h0, irq_o}, {31'h0, m_status[31] & m_control[0]});
    check_eq("ack", {31'h0, csr_status_update_ack_o}, {31'h0, acc_valid && (cyc == acc + 2)});
    check_eq("control", csr_control_o, m_control);
    check_eq("rvalid", {31'h0, csr_readdatavalid}, {31'h0, m_rvalid});
    check_eq("rdata", csr_readdata, m_rdata);

    if (rand_host) begin
      h_reset = ($urandom_range(399) == 0);
      h_read  = ($urandom_range(2) == 0);
      h_write = ($urandom_range(2) == 0);
      h_addr  = ADDR_W'($urandom);
      h_wd    = $urandom;
      h_be    = 4'($urandom);
      h_irq   = ($urandom_range(5) == 0);
    end

    ackn = acc_valid && (cyc == acc + 2);
    if (ackn) begin
      last_ack_cyc = cyc;
      ini_acked    = 1'b1;
      ini_hold     = $urandom_range(2);
    end
    if (ini_acked) begin
      if (ini_hold == 0) begin
        ini_active = 1'b0;
        ini_acked  = 1'b0;
      end else begin
        ini_hold--;
      end
    end else if (!ini_active && (ini_go || (auto_req && $urandom_range(3) == 0))) begin
      if (!ini_go) begin
        ini_data = $urandom;
        ini_be   = 4'($urandom);
      end
      ini_go     = 1'b0;
      ini_active = 1'b1;
      start_cyc  = cyc;
    end
    if (h_reset) begin
      ini_go = 1'b0; ini_active = 1'b0; ini_acked = 1'b0;
    end

    reset                  = h_reset;
    csr_read               = h_read;
    csr_write              = h_write;
    csr_address            = h_addr;
    csr_writedata          = h_wd;
    csr_byteenable         = h_be;
    dma_interrupt_rq_i     = h_irq;
    csr_status_update_rq_i = ini_active;
    csr_status_update_i    = ini_data;
    csr_status_update_be_i = ini_be;

    if (h_reset) begin
      m_status = 32'h0; m_control = 32'h0; m_rdata = 32'h0; m_rvalid = 1'b0;
      acc_valid = 1'b0; busy = 1'b0;
`ifdef DMA_CSR_IRQ_COUNT_EN
      m_cnt = 0;
`endif
    end else begin
      st_wr    = h_write && (h_addr == 0);
      m_rvalid = h_read;
      if (h_read) m_rdata = m_read(int'(h_addr));
      // Accepted at cycle acc: bytes land at the end of acc+1, ack during acc+2.
      if (acc_valid && (cyc == acc + 1)) begin
        merged = m_status;
        for (int i = 0; i < 4; i++)
          if (ini_be[i]) merged[8*i +: 8] = ini_data[8*i +: 8];
        m_status = {m_status[31], merged[30:0]};
      end
      if (busy && (cyc >= acc + 2) && !ini_active)
        busy = 1'b0;
      else if (!busy && ini_active && !st_wr) begin
        busy = 1'b1; acc = cyc; acc_valid = 1'b1;
      end
      if (h_irq)
        m_status[31] = 1'b1;
      else if (st_wr && h_be[3] && h_wd[31])
        m_status[31] = 1'b0;
      if (h_write && (h_addr == 1))
        for (int i = 0; i < 4; i++)
          if (h_be[i]) m_control[8*i +: 8] = h_wd[8*i +: 8];
`ifdef DMA_CSR_IRQ_COUNT_EN
      if (h_write && (h_addr == 2))
        m_cnt = 0;
      else if (h_irq && m_cnt < 65535)
        m_cnt++;
`endif
    end
    cyc++;
  endtask

  task automatic host_write(input int a, input logic [31:0] d, input logic [3:0] be);
    h_write = 1'b1; h_addr = ADDR_W'(a); h_wd = d; h_be = be;
    tick(1'b0, 1'b0);
    idle_host();
    $display("host write addr %0d data %08h be %04b", a, d, be);
  endtask

  task automatic host_read(input int a, output logic [31:0] d);
    h_read = 1'b1; h_addr = ADDR_W'(a);
    tick(1'b0, 1'b0);
    idle_host();
    tick(1'b0, 1'b0);
    d = csr_readdata;
    $display("host read  addr %0d data %08h", a, d);
  endtask

  // Runs one update handshake to completion; host staging applies to the first cycle only.
  task automatic run_update(input logic [31:0] data, input logic [3:0] be, output int lat);
    ini_data = data; ini_be = be; ini_go = 1'b1; last_ack_cyc = -100;
    for (int i = 0; i < 16 && (ini_go || ini_active); i++) begin
      tick(1'b0, 1'b0);
      idle_host();
    end
    check_eq("upd_done", {31'h0, ini_active | ini_go}, 32'h0);
    lat = last_ack_cyc - start_cyc;
    $display("update data %08h be %04b ack latency %0d", data, be, lat);
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    vectors = 0; miscompares = 0;
    cyc = 0; acc = 0; acc_valid = 1'b0; busy = 1'b0;
    m_status = 32'h0; m_control = 32'h0; m_rdata = 32'h0; m_rvalid = 1'b0;
`ifdef DMA_CSR_IRQ_COUNT_EN
    m_cnt = 0;
`endif
    ini_go = 1'b0; ini_active = 1'b0; ini_acked = 1'b0; ini_hold = 0;
    ini_data = 32'h0; ini_be = 4'h0; start_cyc = 0; last_ack_cyc = -100;
    idle_host();
    reset = 1'b1; csr_read = 1'b0; csr_write = 1'b0; csr_address = '0;
    csr_writedata = 32'h0; csr_byteenable = 4'h0; dma_interrupt_rq_i = 1'b0;
    csr_status_update_rq_i = 1'b0; csr_status_update_i = 32'h0; csr_status_update_be_i = 4'h0;
    repeat (2) @(posedge clk);
    h_reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    idle_host();

    host_read(0, d); check_eq("rst_status", d, 32'h0);
    host_read(1, d); check_eq("rst_control", d, 32'h0);

    run_update(32'h0000_00A5, 4'b0001, lat);
    check_eq("sc19_latency", 32'(lat), 32'd2);
    host_read(0, d); check_eq("sc19_status", d, 32'h0000_00A5);

    run_update(32'hFFFF_FFFF, 4'hF, lat);
    host_read(0, d); check_eq("sc20_status", d, 32'h7FFF_FFFF);

    host_write(1, 32'h0000_0001, 4'b0001);
    h_irq = 1'b1; tick(1'b0, 1'b0); idle_host();
    tick(1'b0, 1'b0);
    check_eq("sc21_irq_set", {31'h0, irq_o}, 32'h1);
    host_write(0, 32'h8000_0000, 4'b1000);
    tick(1'b0, 1'b0);
    check_eq("sc21_irq_clr", {31'h0, irq_o}, 32'h0);
    h_irq = 1'b1; tick(1'b0, 1'b0); idle_host();
    h_irq = 1'b1; host_write(0, 32'h8000_0000, 4'b1000);
    tick(1'b0, 1'b0);
    check_eq("sc21_irq_race", {31'h0, irq_o}, 32'h1);

    h_write = 1'b1; h_addr = '0; h_wd = 32'h8000_0000; h_be = 4'b1000;
    run_update(32'h0000_0012, 4'b0001, lat);
    check_eq("sc22_latency", 32'(lat), 32'd3);
    host_read(0, d); check_eq("sc22_status", d, 32'h7FFF_FF12);

    ini_data = 32'h3C3C_3C3C; ini_be = 4'hF; ini_go = 1'b1;
    tick(1'b0, 1'b0);
    h_reset = 1'b1; tick(1'b0, 1'b0); idle_host();
    repeat (4) tick(1'b0, 1'b0);
    host_read(0, d); check_eq("sc23_status", d, 32'h0);
    run_update(32'h0000_5A00, 4'b0010, lat);
    check_eq("sc23_idle_latency", 32'(lat), 32'd2);

    for (int i = 0; i < 3; i++) begin
      h_irq = 1'b1; tick(1'b0, 1'b0); idle_host(); tick(1'b0, 1'b0);
    end
    host_read(2, d);
`ifdef DMA_CSR_IRQ_COUNT_EN
    check_eq("sc24_count", d, 32'd3);
`else
    check_eq("sc24_count", d, 32'd0);
`endif
    host_write(2, 32'hFFFF_FFFF, 4'hF);
    host_read(2, d); check_eq("sc24_cleared", d, 32'd0);
    host_read(5, d); check_eq("unmapped", d, 32'd0);

    for (int i = 0; i < 4000; i++) tick(1'b1, 1'b1);
    idle_host();
    repeat (8) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_csr.md
DMA_CSR -- requirements
Module: dma_csr

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning CSR word-address width.
REQ-002 SHALL have ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- csr_address  in  ADDR_W  host word address
- csr_read  in  1  host read strobe
- csr_write  in  1  host write strobe
- csr_writedata  in  32  host write data
- csr_byteenable  in  4  host byte enables
- csr_readdata  out  32  registered read data
- csr_readdatavalid  out  1  read data valid
- csr_status_update_i  in  32  status value from the status-update initiator
- csr_status_update_be_i  in  4  byte enables for the status update
- csr_status_update_rq_i  in  1  update request; held high until acked
- csr_status_update_ack_o  out  1  one-cycle update acknowledge
- dma_interrupt_rq_i  in  1  interrupt-event pulse from the status-update block
- csr_control_o  out  32  CONTROL register contents
- irq_o  out  1  level interrupt to host

Function
REQ-003 SHALL implement the register map: 0 STATUS, 1 CONTROL, 2 IRQ_COUNT (macro-dependent), all other addresses read 0 and ignore writes.
REQ-004 SHALL write CONTROL per enabled byte on csr_write to address 1; csr_control_o equals CONTROL; bit 0 is global interrupt enable (IE).
REQ-005 SHALL treat STATUS[31] as IRQ_PENDING: set when dma_interrupt_rq_i=1, cleared by a host write to address 0 with byteenable[3]=1 and writedata[31]=1; on a simultaneous set and clear, set wins.
REQ-006 SHALL ignore host writes to STATUS[30:0].
REQ-007 SHALL drive irq_o combinationally as IRQ_PENDING AND CONTROL[0].
REQ-008 SHALL return csr_readdata and assert csr_readdatavalid for exactly one cycle, in the cycle after csr_read; the returned data is the register value sampled in the csr_read cycle.
REQ-009 SHALL handle status-update requests with a 4-state FSM:
- IDLE: moves to UPDATE when rq_i=1 and no host write to address 0 occurs in the same cycle; otherwise stays in IDLE, deferring the request by one cycle.
- UPDATE: loads STATUS[30:0] from csr_status_update_i for enabled bytes (the byte-3 enable affects bits 30:24 only); moves to ACK.
- ACK: csr_status_update_ack_o=1; moves to RELEASE if rq_i=1, else to IDLE.
- RELEASE: waits until rq_i=0, then moves to IDLE.
REQ-010 SHALL never let a status update modify IRQ_PENDING.
REQ-011 SHALL give a worst-case request-to-ack latency of 2 cycles in the absence of host STATUS writes: rq seen in cycle N, STATUS updated at the end of N+1, ack in N+2.
REQ-012 SHALL drive csr_status_update_ack_o from a register and assert it only in state ACK.

Reset
REQ-013 On reset=1 the block SHALL set: FSM to IDLE; STATUS, CONTROL and IRQ_COUNT to 0; csr_readdata to 0; csr_readdatavalid, csr_status_update_ack_o and irq_o to 0.
REQ-014 Reset mid-update SHALL drop the in-flight request without an ack; after reset the initiator must re-request.

Configuration
REQ-015 With macro DMA_CSR_IRQ_COUNT_EN defined, the block SHALL implement IRQ_COUNT at address 2:
- 16-bit counter, zero-extended to 32 bits on read.
- Increments on each dma_interrupt_rq_i pulse and saturates at 0xFFFF.
- Any host write to address 2 clears it.
REQ-016 Without DMA_CSR_IRQ_COUNT_EN, the block SHALL have no counter logic, and address 2 SHALL read 0 and ignore writes.

Structure
REQ-017 Shared package dma_csr_pkg SHALL hold:
- register address constants (STATUS, CONTROL, IRQ_COUNT);
- bit positions IRQ_PENDING_BIT=31 and IE_BIT=0;
- the update-FSM state type (IDLE, UPDATE, ACK, RELEASE).
REQ-018 The update FSM SHALL be a sub-module named dma_csr_update_fsm; the register file and read mux stay in dma_csr.

Verification
REQ-019 Scenario: rq_i=1 with status 0x0000_00A5 and be=4'b0001, held until ack -> STATUS reads 0x0000_00A5; ack is exactly one cycle, 2 cycles after rq.
REQ-020 Scenario: update with status 0xFFFF_FFFF, be=4'hF, IRQ_PENDING=0 -> STATUS reads 0x7FFF_FFFF.
REQ-021 Scenario: CONTROL=0x1, then a dma_interrupt_rq_i pulse -> irq_o=1; host writes 0x8000_0000 to address 0 with be=4'b1000 -> irq_o=0 the next cycle; a write and a pulse in the same cycle -> irq_o stays 1.
REQ-022 Scenario: rq_i in the same cycle as a host write to address 0 -> ack 1 cycle later than in REQ-019; both effects visible in STATUS.
REQ-023 Scenario: reset asserted in state UPDATE -> no ack; STATUS=0; FSM in IDLE.
REQ-024 Scenario (DMA_CSR_IRQ_COUNT_EN): 3 interrupt pulses -> address 2 reads 3; host write to address 2 -> reads 0; without the macro -> address 2 reads 0.
